or_bus_arbiter: RTL and testbench



---
 rtl/or_bus_pkg.sv | 13 +
 rtl/or_bus_arbiter_rr_pick.sv | 35 +++
 rtl/or_bus_arbiter.sv | 114 +++++++++++
 tb/tb_or_bus_arbiter.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/or_bus_pkg.sv
// Shared state encoding and default sizing for the OR-bus arbiter.
package or_bus_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  localparam int N_DEF        = 4;
  localparam int W_DEF        = 8;
  localparam int MAX_HOLD_DEF = 15;

endpackage

// File: rtl/or_bus_arbiter_rr_pick.sv
// Rotating priority finder: first requester after `last`, skipping excluded ports.
// Purely combinational.
module rr_pick
  import or_bus_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int LW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] last,
  input  logic [N-1:0]  excl,
  output logic          found,
  output logic [LW-1:0] idx
);

  int            j;
  logic [LW-1:0] jj;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = 0;
    jj    = '0;
    // k == N revisits `last` itself, so the previous owner is last in line
    for (int k = 1; k <= N; k++) begin
      j  = (int'(last) + k) % N;
      jj = LW'(j);
      if (!found && req[jj] && !excl[jj]) begin
        found = 1'b1;
        idx   = jj;
      end
    end
  end

endmodule

// File: rtl/or_bus_arbiter.sv
// Round-robin owner of a shared AND-OR bus: registered one-hot grant, hold timeout,
// back-to-back handover. Grant follows req by one cycle; bus_data is combinational from gnt.
module or_bus_arbiter
  import or_bus_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int W        = W_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  parameter int LW       = (N > 1) ? $clog2(N) : 1,
  parameter int CW       = $clog2(MAX_HOLD + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] data_in,
  output logic [N-1:0]   gnt,
  output logic [LW-1:0]  gnt_id,
  output logic           busy,
  output logic [W-1:0]   bus_data
);

  state_t        state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [LW-1:0] last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          run_q;

  logic          found;
  logic [LW-1:0] win;
  logic [N-1:0]  excl;
  logic          owner_req;
  logic [N-1:0]  one;

  assign one       = {{(N-1){1'b0}}, 1'b1};
  assign owner_req = |(req & gnt_q);
  assign excl      = (state_q == OWNED) ? gnt_q : '0;

  rr_pick #(.N(N), .LW(LW)) u_pick (
    .req   (req),
    .last  (last_q),
    .excl  (excl),
    .found (found),
    .idx   (win)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (run_q && found) begin
          state_d = OWNED;
          gnt_d   = one << win;
          last_d  = win;
          cnt_d   = CW'(1);
        end
      end
      OWNED: begin
        if (owner_req && (cnt_q < CW'(MAX_HOLD))) begin
          cnt_d = cnt_q + CW'(1);
        end else if (found) begin
          // timeout preemption or release handover, both without an idle cycle
          gnt_d  = one << win;
          last_d = win;
          cnt_d  = CW'(1);
        end else if (!owner_req) begin
          state_d = IDLE;
          gnt_d   = '0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // run_q delays arbitration until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= LW'(N - 1);
      cnt_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      run_q   <= 1'b1;
    end
  end

  assign gnt    = gnt_q;
  assign busy   = |gnt_q;
  assign gnt_id = (state_q == OWNED) ? last_q : '0;

  logic [W-1:0] masked [N];

  for (genvar i = 0; i < N; i++) begin : g_and
    assign masked[i] = data_in[i*W +: W] & {W{gnt_q[i]}};
  end

  always_comb begin
    bus_data = '0;
    for (int i = 0; i < N; i++) bus_data = bus_data | masked[i];
  end

endmodule

// File: tb/tb_or_bus_arbiter.sv
// Scenario bench for or_bus_arbiter: expected owners queued as stimulus is driven,
// popped and compared after each clock edge.
module tb_or_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] data_in;

  logic [3:0]  gnt, gnt2;
  logic [1:0]  gnt_id, gnt_id2;
  logic        busy, busy2;
  logic [7:0]  bus_data, bus_data2;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  or_bus_arbiter #(.N(4), .W(8), .MAX_HOLD(15)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .data_in(data_in),
    .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .bus_data(bus_data)
  );

  or_bus_arbiter #(.N(4), .W(8), .MAX_HOLD(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req(req), .data_in(data_in),
    .gnt(gnt2), .gnt_id(gnt_id2), .busy(busy2), .bus_data(bus_data2)
  );

  function automatic logic [3:0] onehot(input int idx);
    logic [3:0] v;
    v = 4'b0000;
    if (idx >= 0) v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [7:0] lane(input logic [31:0] d, input int idx);
    return (idx >= 0) ? d[idx*8 +: 8] : 8'h00;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // reset held across one edge, released mid-cycle with req already applied
  task automatic apply_reset(input logic [3:0] r);
    rst_n = 1'b0;
    req   = r;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    int e;
    rst_n   = 1'b0;
    req     = 4'b1111;
    data_in = {8'hF0, 8'h0F, 8'hAA, 8'h55};
    step();
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
    n_checks++; if (bus_data !== 8'h00) begin n_fail++; $display("FAIL reset_bus got=%h exp=00", bus_data); end
    n_checks++; if (busy !== 1'b0 || gnt_id !== 2'd0) begin n_fail++; $display("FAIL reset_busy_id got=%b/%0d exp=0/0", busy, gnt_id); end
    req   = 4'b0001;
    rst_n = 1'b1;
    exp_q.push_back(-1);
    exp_q.push_back(0);
    repeat (2) begin
      step();
      e = exp_q.pop_front();
      n_checks++; if (gnt !== onehot(e)) begin n_fail++; $display("FAIL release_gnt got=%b exp=%b", gnt, onehot(e)); end
      n_checks++; if (bus_data !== lane(data_in, e)) begin n_fail++; $display("FAIL release_bus got=%h exp=%h", bus_data, lane(data_in, e)); end
    end
  endtask

  task automatic test_rotation();
    int e;
    apply_reset(4'b1111);
    exp_q.push_back(-1);
    foreach (exp_q[k]) ;
    begin
      int seq[9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
      foreach (seq[k]) exp_q.push_back(seq[k]);
    end
    while (exp_q.size() > 0) begin
      step();
      e = exp_q.pop_front();
      n_checks++; if (gnt2 !== onehot(e)) begin n_fail++; $display("FAIL rotation_gnt got=%b exp=%b", gnt2, onehot(e)); end
      n_checks++; if (gnt_id2 !== ((e < 0) ? 2'd0 : 2'(e))) begin n_fail++; $display("FAIL rotation_id got=%0d exp=%0d", gnt_id2, (e < 0) ? 0 : e); end
    end
  endtask

  task automatic test_back_to_back();
    int e;
    apply_reset(4'b0100);
    exp_q.push_back(-1); step(); e = exp_q.pop_front();
    n_checks++; if (gnt !== onehot(e)) begin n_fail++; $display("FAIL b2b_wait got=%b exp=%b", gnt, onehot(e)); end
    exp_q.push_back(2); step(); e = exp_q.pop_front();
    n_checks++; if (gnt !== onehot(e)) begin n_fail++; $display("FAIL b2b_own2 got=%b exp=%b", gnt, onehot(e)); end
    req = 4'b1100;
    exp_q.push_back(2); step(); e = exp_q.pop_front();
    n_checks++; if (gnt !== onehot(e)) begin n_fail++; $display("FAIL b2b_hold2 got=%b exp=%b", gnt, onehot(e)); end
    req = 4'b1000;
    exp_q.push_back(3); step(); e = exp_q.pop_front();
    n_checks++; if (gnt !== onehot(e) || busy !== 1'b1) begin n_fail++; $display("FAIL b2b_handoff got=%b busy=%b exp=%b busy=1", gnt, busy, onehot(e)); end
    n_checks++; if (gnt_id !== 2'd3) begin n_fail++; $display("FAIL b2b_id got=%0d exp=3", gnt_id); end
  endtask

  task automatic test_hold_timeout();
    int e;
    apply_reset(4'b0010);
    step();
    repeat (40) exp_q.push_back(1);
    while (exp_q.size() > 0) begin
      step();
      e = exp_q.pop_front();
      n_checks++; if (gnt !== onehot(e)) begin n_fail++; $display("FAIL hold_gnt got=%b exp=%b", gnt, onehot(e)); end
    end
    n_checks++; if (dut.cnt_q !== 4'd15) begin n_fail++; $display("FAIL hold_cnt got=%0d exp=15", dut.cnt_q); end
    req = 4'b0011;
    exp_q.push_back(0); step(); e = exp_q.pop_front();
    n_checks++; if (gnt !== onehot(e)) begin n_fail++; $display("FAIL hold_preempt got=%b exp=%b", gnt, onehot(e)); end
  endtask

  task automatic test_bus_data();
    data_in = {8'hF0, 8'h0F, 8'hAA, 8'h55};
    apply_reset(4'b0010);
    step(); step();
    n_checks++; if (bus_data !== 8'hAA) begin n_fail++; $display("FAIL bus_owner1 got=%h exp=aa", bus_data); end
    req = 4'b0000;
    step();
    n_checks++; if (bus_data !== 8'h00 || gnt !== 4'b0000) begin n_fail++; $display("FAIL bus_idle got=%h/%b exp=00/0000", bus_data, gnt); end
    req = 4'b1000;
    step();
    n_checks++; if (bus_data !== 8'hF0) begin n_fail++; $display("FAIL bus_owner3 got=%h exp=f0", bus_data); end
  endtask

  task automatic test_async_reset();
    apply_reset(4'b1000);
    step(); step();
    n_checks++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL arst_own3 got=%b exp=1000", gnt); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (gnt !== 4'b0000 || busy !== 1'b0) begin n_fail++; $display("FAIL arst_clear got=%b busy=%b exp=0000 busy=0", gnt, busy); end
    n_checks++; if (bus_data !== 8'h00 || gnt_id !== 2'd0) begin n_fail++; $display("FAIL arst_bus_id got=%h/%0d exp=00/0", bus_data, gnt_id); end
    req = 4'b1111;
    step();
    rst_n = 1'b1;
    step(); step();
    n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL arst_first got=%b exp=0001", gnt); end
  endtask

  initial begin
    rst_n   = 1'b0;
    req     = 4'b0000;
    data_in = 32'h0;
    test_reset();
    test_rotation();
    test_back_to_back();
    test_hold_timeout();
    test_bus_data();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
